// File: rtl/prog_byte_loader.sv
// Framed byte-stream loader: assembles big-endian 32-bit words from CMD/LEN/[ADDR]/WORDS/CSUM
// frames and streams them to the instruction or data port, with checksum and idle-timeout checks.
module prog_byte_loader #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  CMD_INS        = 8'hA5,
    parameter logic [7:0]  CMD_DATA       = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_vld,
    output logic [31:0] ins_o,
    output logic        ins_vld,
    output logic [31:0] data_o,
    output logic [31:0] data_addr_o,
    output logic        data_vld,
    output logic        loading,
    output logic        done,
    output logic        err
);

    localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_ADDR,
        S_WORD,
        S_CSUM
    } state_t;

    state_t        state_q;
    logic          is_data_q;
    logic [7:0]    len_q;
    logic [7:0]    wcnt_q;
    logic [1:0]    bidx_q;
    logic [31:0]   word_q;
    logic [31:0]   addr_q;
    logic [7:0]    csum_q;
    logic [TW-1:0] timer_q;

    logic [31:0]   ins_q;
    logic          ins_vld_q;
    logic [31:0]   data_q;
    logic [31:0]   data_addr_q;
    logic          data_vld_q;
    logic          loading_q;
    logic          done_q;
    logic          err_q;

    logic [31:0]   word_d;
    logic [7:0]    csum_d;
    logic [7:0]    wcnt_d;

    assign word_d = {word_q[23:0], rx_byte};
    assign csum_d = csum_q ^ rx_byte;
    assign wcnt_d = wcnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            is_data_q   <= 1'b0;
            len_q       <= '0;
            wcnt_q      <= '0;
            bidx_q      <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            csum_q      <= '0;
            timer_q     <= '0;
            ins_q       <= '0;
            ins_vld_q   <= 1'b0;
            data_q      <= '0;
            data_addr_q <= '0;
            data_vld_q  <= 1'b0;
            loading_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ins_vld_q  <= 1'b0;
            data_vld_q <= 1'b0;
            done_q     <= 1'b0;

            if (state_q == S_IDLE) begin
                timer_q <= '0;
                if (rx_vld && (rx_byte == CMD_INS || rx_byte == CMD_DATA)) begin
                    state_q   <= S_LEN;
                    is_data_q <= (rx_byte == CMD_DATA);
                    loading_q <= 1'b1;
                    err_q     <= 1'b0;
                    csum_q    <= '0;
                    wcnt_q    <= '0;
                    bidx_q    <= '0;
                end
            end else if (timer_q == TMAX) begin
                // Timeout wins over a byte arriving in the same cycle; that byte is dropped.
                state_q   <= S_IDLE;
                err_q     <= 1'b1;
                loading_q <= 1'b0;
                timer_q   <= '0;
            end else begin
                timer_q <= rx_vld ? '0 : timer_q + TW'(1);
                if (rx_vld) begin
                    case (state_q)
                        S_LEN: begin
                            csum_q <= csum_d;
                            bidx_q <= '0;
                            if (rx_byte == 8'd0) begin
                                state_q   <= S_IDLE;
                                err_q     <= 1'b1;
                                loading_q <= 1'b0;
                            end else begin
                                len_q   <= rx_byte;
                                state_q <= is_data_q ? S_ADDR : S_WORD;
                            end
                        end
                        S_ADDR: begin
                            csum_q <= csum_d;
                            word_q <= word_d;
                            bidx_q <= bidx_q + 2'd1;
                            if (bidx_q == 2'd3) begin
                                addr_q  <= word_d;
                                state_q <= S_WORD;
                            end
                        end
                        S_WORD: begin
                            csum_q <= csum_d;
                            word_q <= word_d;
                            bidx_q <= bidx_q + 2'd1;
                            if (bidx_q == 2'd3) begin
                                if (is_data_q) begin
                                    data_q      <= word_d;
                                    data_addr_q <= addr_q;
                                    data_vld_q  <= 1'b1;
                                    addr_q      <= addr_q + 32'd4;
                                end else begin
                                    ins_q     <= word_d;
                                    ins_vld_q <= 1'b1;
                                end
                                wcnt_q <= wcnt_d;
                                if (wcnt_d == len_q) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        end
                        S_CSUM: begin
                            if (rx_byte == csum_q) begin
                                done_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            loading_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                        default: begin
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign ins_o       = ins_q;
    assign ins_vld     = ins_vld_q;
    assign data_o      = data_q;
    assign data_addr_o = data_addr_q;
    assign data_vld    = data_vld_q;
    assign loading     = loading_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_prog_byte_loader.sv
// Directed bench for prog_byte_loader: table of whole frames plus hand-written timeout/reset sequences.
module tb_prog_byte_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic [31:0] ins_o;
    logic        ins_vld;
    logic [31:0] data_o;
    logic [31:0] data_addr_o;
    logic        data_vld;
    logic        loading;
    logic        done;
    logic        err;

    prog_byte_loader #(
        .TIMEOUT_CYCLES(16),
        .CMD_INS       (8'hA5),
        .CMD_DATA      (8'h5A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte    (rx_byte),
        .rx_vld     (rx_vld),
        .ins_o      (ins_o),
        .ins_vld    (ins_vld),
        .data_o     (data_o),
        .data_addr_o(data_addr_o),
        .data_vld   (data_vld),
        .loading    (loading),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Pulse monitor: logs every word pulse, done pulse and illegal overlap.
    logic [31:0] ins_log  [64];
    logic [31:0] dat_log  [64];
    logic [31:0] adr_log  [64];
    int ins_n  = 0;
    int dat_n  = 0;
    int done_n = 0;
    int ovl_n  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ins_vld && ins_n < 64) begin
                ins_log[ins_n] = ins_o;
                ins_n = ins_n + 1;
            end
            if (data_vld && dat_n < 64) begin
                dat_log[dat_n] = data_o;
                adr_log[dat_n] = data_addr_o;
                dat_n = dat_n + 1;
            end
            if (done) done_n = done_n + 1;
            if (ins_vld && data_vld) ovl_n = ovl_n + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte = b;
        rx_vld  = 1'b1;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {29'd0, ins_vld, data_vld, done}, 32'd0);
        chk({name, "_flags"}, {30'd0, loading, err}, 32'd0);
        chk({name, "_ins"}, ins_o, 32'd0);
        chk({name, "_data"}, data_o, 32'd0);
        chk({name, "_addr"}, data_addr_o, 32'd0);
    endtask

    typedef struct {
        string        name;
        logic [127:0] raw;     // bytes right-justified, first byte most significant
        int           n;
        int           n_ins;
        int           n_dat;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [31:0]  a0;
        logic [31:0]  a1;
        int           n_done;
        logic         exp_err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int s_ins, s_dat, s_done, s_ovl;

        vecs[0] = '{"ins_frame", 128'({8'hA5, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10, 8'h20, 8'h22,
                                      8'h00, 8'h05, 8'h28}), 11,
                    2, 0, 32'h3C010010, 32'h20220005, 32'h0, 32'h0, 1, 1'b0};
        vecs[1] = '{"junk", 128'(8'h33), 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0};
        vecs[2] = '{"data_frame", 128'({8'h5A, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD,
                                       8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h07, 8'h37}), 15,
                    0, 2, 32'hDEADBEEF, 32'h00000007, 32'h10, 32'h14, 1, 1'b0};
        vecs[3] = '{"bad_csum", 128'({8'hA5, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10, 8'h20, 8'h22,
                                     8'h00, 8'h05, 8'h29}), 11,
                    2, 0, 32'h3C010010, 32'h20220005, 32'h0, 32'h0, 0, 1'b1};
        vecs[4] = '{"zero_len", 128'({8'hA5, 8'h00}), 2, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b1};

        rst_n   = 1'b0;
        rx_byte = 8'h00;
        rx_vld  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            s_ins  = ins_n;
            s_dat  = dat_n;
            s_done = done_n;
            s_ovl  = ovl_n;
            for (int k = 0; k < vecs[i].n; k++) begin
                send_byte(vecs[i].raw[(vecs[i].n - 1 - k) * 8 +: 8]);
            end
            idle(3);
            chk({vecs[i].name, "_ins_cnt"}, ins_n - s_ins, vecs[i].n_ins);
            chk({vecs[i].name, "_dat_cnt"}, dat_n - s_dat, vecs[i].n_dat);
            chk({vecs[i].name, "_done_cnt"}, done_n - s_done, vecs[i].n_done);
            chk({vecs[i].name, "_overlap"}, ovl_n - s_ovl, 0);
            chk({vecs[i].name, "_err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk({vecs[i].name, "_loading"}, {31'd0, loading}, 32'd0);
            if (vecs[i].n_ins == 2 && ins_n - s_ins == 2) begin
                chk({vecs[i].name, "_ins0"}, ins_log[s_ins], vecs[i].w0);
                chk({vecs[i].name, "_ins1"}, ins_log[s_ins + 1], vecs[i].w1);
            end
            if (vecs[i].n_dat == 2 && dat_n - s_dat == 2) begin
                chk({vecs[i].name, "_dat0"}, dat_log[s_dat], vecs[i].w0);
                chk({vecs[i].name, "_adr0"}, adr_log[s_dat], vecs[i].a0);
                chk({vecs[i].name, "_dat1"}, dat_log[s_dat + 1], vecs[i].w1);
                chk({vecs[i].name, "_adr1"}, adr_log[s_dat + 1], vecs[i].a1);
            end
        end

        // Word-pulse latency: exactly one cycle after the last byte of a word.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
        chk("lat_ins_vld", {31'd0, ins_vld}, 32'd1);
        chk("lat_ins_word", ins_o, 32'h11223344);
        send_byte(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
        chk("lat_done", {31'd0, done, loading, err}, 32'd4);
        idle(2);
        chk("hold_ins", ins_o, 32'h11223344);

        // Timeout mid-word.
        s_ins = ins_n;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h3C);
        send_byte(8'h01);
        idle(10);
        chk("to_before", {30'd0, loading, err}, 32'd2);
        idle(10);
        chk("to_after", {30'd0, loading, err}, 32'd1);
        chk("to_no_ins", ins_n - s_ins, 0);
        send_byte(8'hA5);
        idle(2);
        chk("to_clear", {30'd0, loading, err}, 32'd2);
        idle(20);
        chk("to_len", {30'd0, loading, err}, 32'd1);

        // Reset mid-word, then a clean frame.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h3C);
        send_byte(8'h01);
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        s_ins  = ins_n;
        s_done = done_n;
        for (int k = 0; k < vecs[0].n; k++) begin
            send_byte(vecs[0].raw[(vecs[0].n - 1 - k) * 8 +: 8]);
        end
        idle(3);
        chk("post_rst_ins_cnt", ins_n - s_ins, 2);
        chk("post_rst_done", done_n - s_done, 1);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        if (ins_n - s_ins == 2) begin
            chk("post_rst_ins0", ins_log[s_ins], 32'h3C010010);
            chk("post_rst_ins1", ins_log[s_ins + 1], 32'h20220005);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
